snax_csr_router: RTL and testbench
==================================

# snax_csr_router

Parametrised N-way CSR request router with in-order read-response return. It generalises the fixed two-way streamer/accelerator CSR split to NumTargets address windows. It rebases each forwarded address to its window and tracks outstanding reads in an ordering FIFO, so responses reach the core in issue order. It sits between the core-side SNAX CSR port and the per-target CSR managers (streamers, accelerator CSR manager, extra units) inside an accelerator wrapper.

## Interface
- NumTargets, 2, number of downstream CSR targets (≥2).
- RegAddrWidth, 32, CSR address width.
- RegDataWidth, 32, CSR data width.
- TargetBase, {47}, packed array [NumTargets-2:0][RegAddrWidth-1:0] of window start addresses for targets 1..N-1, strictly ascending; target 0 starts at 0.
- MaxOutstanding, 4, ordering FIFO depth (≥1).

Ports:
- clk_i  in  1  clock; everything is on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- csr_req_addr_i  in  RegAddrWidth  core request address.
- csr_req_data_i  in  RegDataWidth  core write data.
- csr_req_wen_i  in  1  1 = write, 0 = read.
- csr_req_valid_i  in  1  request valid.
- csr_req_ready_o  out  1  request ready.
- csr_rsp_data_o  out  RegDataWidth  read data to core.
- csr_rsp_valid_o  out  1  response valid.
- csr_rsp_ready_i  in  1  core response ready.
- acc_csr_req_addr_o  out  [NumTargets][RegAddrWidth]  rebased address per target.
- acc_csr_req_data_o  out  [NumTargets][RegDataWidth]  write data per target.
- acc_csr_req_wen_o  out  [NumTargets]  write enable per target.
- acc_csr_req_valid_o  out  [NumTargets]  request valid per target.
- acc_csr_req_ready_i  in  [NumTargets]  target request ready.
- acc_csr_rsp_data_i  in  [NumTargets][RegDataWidth]  target read data.
- acc_csr_rsp_valid_i  in  [NumTargets]  target response valid.
- acc_csr_rsp_ready_o  out  [NumTargets]  response ready per target.
- busy_o  out  1  at least one read is outstanding.

## Operation
- Target select: t = number of TargetBase entries ≤ csr_req_addr_i. Target 0 covers [0, TargetBase[0]). The last target is open-ended. No address is unmapped.
- Forwarded address = csr_req_addr_i − base(t), with base(0)=0. Data and wen pass unmodified.
- acc_csr_req_valid_o[t] = csr_req_valid_i && (wen || !full). All other targets see valid=0.
- csr_req_ready_o = acc_csr_req_ready_i[t] && (wen || !full).
- Writes produce no response and do not touch the FIFO.
- Accepted read (valid && ready && !wen): push t into the ordering FIFO, which is $clog2(NumTargets) bits wide and MaxOutstanding deep.
- Response path when the FIFO is non-empty, with h = FIFO head:
  - csr_rsp_valid_o = acc_csr_rsp_valid_i[h]
  - csr_rsp_data_o = acc_csr_rsp_data_i[h]
  - acc_csr_rsp_ready_o[h] = csr_rsp_ready_i
  - all other acc_csr_rsp_ready_o = 0
- Response path when the FIFO is empty: csr_rsp_valid_o=0, csr_rsp_data_o=0, all acc_csr_rsp_ready_o=0. A target response arriving with no matching entry is held off, never dropped or forwarded.
- Pop on csr_rsp_valid_o && csr_rsp_ready_i.
- Occupancy counter is $clog2(MaxOutstanding+1) bits: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- Read and write pointers wrap modulo MaxOutstanding.
- full = (count == MaxOutstanding). Push is gated on full only, with no same-cycle pop bypass.
- busy_o = (count != 0).

## Timing
- Request and response paths are combinational pass-through: zero cycles of added latency. Only the FIFO pointers and counter are registered.
- Reset values: count=0, pointers=0, busy_o=0, csr_rsp_valid_o=0, csr_rsp_data_o=0, all acc_csr_rsp_ready_o=0. Request-side outputs follow the inputs combinationally.
- Reset mid-operation: the FIFO flushes at the first edge with rst_i=1. Outstanding reads are forgotten, and targets must be reset in the same cycle. A request presented while rst_i=1 is not recorded.
- Handshake rules on both sides:
  - valid must not depend on ready.
  - Core-side payload is stable while valid && !ready.
  - The router never deasserts acc_csr_req_valid_o[t] mid-transaction unless csr_req_valid_i drops.
- Full FIFO, read at head: csr_req_ready_o=0 and the target sees valid=0. A write to any target still proceeds.
- Full FIFO with a pop in the same cycle: a new read is still refused that cycle and is accepted the next cycle.
- Responses arriving out of order from different targets are serialised in issue order. A younger target's response waits with ready=0.

## Test plan
- Routing/rebase: NumTargets=3, TargetBase={60,47}.
  - Write addr 10 → target 0, addr 10.
  - Write addr 50 → target 1, addr 3.
  - Write addr 70 → target 2, addr 10.
  - No responses; busy_o stays 0.
- In-order return:
  - Read target 2 (addr 65), then read target 0 (addr 5).
  - Target 0 responds 0xAAAA first: held with acc_csr_rsp_ready_o[0]=0.
  - Target 2 responds 0x1234: core receives 0x1234 then 0xAAAA.
  - busy_o falls after the second pop.
- Full: MaxOutstanding=4, issue 4 reads with targets not responding.
  - 5th read: csr_req_ready_o=0.
  - A concurrent write to target 1 is accepted.
  - One pop → 5th read accepted on the following cycle.
- Simultaneous push/pop: count=2, read accepted in the same cycle as a response pop → count stays 2 and FIFO order is preserved.
- Wrap-around: 10 back-to-back read/response pairs alternating targets 0 and 1 with MaxOutstanding=4 → every response is routed correctly across pointer wrap.
- Reset mid-operation: 3 reads outstanding, assert rst_i for 1 cycle → busy_o=0 and csr_rsp_valid_o=0 next cycle; a subsequent read/response completes normally.

Source files
------------

// File: rtl/snax_csr_router.sv
// snax_csr_router: N-way windowed CSR request router with in-order read-response return
module snax_csr_router #(
  parameter int unsigned NumTargets = 2,
  parameter int unsigned RegAddrWidth = 32,
  parameter int unsigned RegDataWidth = 32,
  parameter logic [NumTargets-2:0][RegAddrWidth-1:0] TargetBase = 47,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic [RegAddrWidth-1:0]                 csr_req_addr_i,
  input  logic [RegDataWidth-1:0]                 csr_req_data_i,
  input  logic                                    csr_req_wen_i,
  input  logic                                    csr_req_valid_i,
  output logic                                    csr_req_ready_o,
  output logic [RegDataWidth-1:0]                 csr_rsp_data_o,
  output logic                                    csr_rsp_valid_o,
  input  logic                                    csr_rsp_ready_i,
  output logic [NumTargets-1:0][RegAddrWidth-1:0] acc_csr_req_addr_o,
  output logic [NumTargets-1:0][RegDataWidth-1:0] acc_csr_req_data_o,
  output logic [NumTargets-1:0]                   acc_csr_req_wen_o,
  output logic [NumTargets-1:0]                   acc_csr_req_valid_o,
  input  logic [NumTargets-1:0]                   acc_csr_req_ready_i,
  input  logic [NumTargets-1:0][RegDataWidth-1:0] acc_csr_rsp_data_i,
  input  logic [NumTargets-1:0]                   acc_csr_rsp_valid_i,
  output logic [NumTargets-1:0]                   acc_csr_rsp_ready_o,
  output logic                                    busy_o
);
  localparam int unsigned TW = $clog2(NumTargets);
  localparam int unsigned PW = MaxOutstanding > 1 ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CW = $clog2(MaxOutstanding + 1);
  logic [TW-1:0] sel, head;
  logic [RegAddrWidth-1:0] base;
  logic [TW-1:0] fifo_q [MaxOutstanding];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic full, empty, push, pop;
  // windows are ascending, so the last base not above the address wins
  always_comb begin
    sel = '0;
    base = '0;
    for (int i = 0; i < NumTargets - 1; i++)
      if (csr_req_addr_i >= TargetBase[i]) begin
        sel = TW'(i + 1);
        base = TargetBase[i];
      end
  end
  assign full = count == CW'(MaxOutstanding);
  assign empty = count == '0;
  assign head = fifo_q[rd_ptr];
  assign csr_req_ready_o = acc_csr_req_ready_i[sel] && (csr_req_wen_i || !full);
  assign push = csr_req_valid_i && csr_req_ready_o && !csr_req_wen_i;
  assign csr_rsp_valid_o = !empty && acc_csr_rsp_valid_i[head];
  assign csr_rsp_data_o = empty ? '0 : acc_csr_rsp_data_i[head];
  assign pop = csr_rsp_valid_o && csr_rsp_ready_i;
  assign busy_o = !empty;
  always_comb begin
    for (int t = 0; t < NumTargets; t++) begin
      acc_csr_req_addr_o[t] = csr_req_addr_i - base;
      acc_csr_req_data_o[t] = csr_req_data_i;
      acc_csr_req_wen_o[t] = csr_req_wen_i;
      acc_csr_req_valid_o[t] = csr_req_valid_i && (csr_req_wen_i || !full) && sel == TW'(t);
      acc_csr_rsp_ready_o[t] = !empty && head == TW'(t) && csr_rsp_ready_i;
    end
  end
  always_ff @(posedge clk_i)
    if (push) fifo_q[wr_ptr] <= sel;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr == PW'(MaxOutstanding - 1) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr == PW'(MaxOutstanding - 1) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: tb/tb_snax_csr_router.sv
// tb_snax_csr_router: directed checks of routing, rebase, ordering, full, wrap and reset
module tb_snax_csr_router;
  logic clk = 0, rst = 1;
  logic [31:0] req_addr = 0, req_data = 0, rsp_data;
  logic req_wen = 0, req_valid = 0, req_ready, rsp_valid, rsp_ready = 1, busy;
  logic [2:0][31:0] acc_addr, acc_data, acc_rsp_data;
  logic [2:0] acc_wen, acc_valid, acc_req_ready = 3'b111, acc_rsp_valid = 0, acc_rsp_ready;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  snax_csr_router #(
    .NumTargets(3), .RegAddrWidth(32), .RegDataWidth(32),
    .TargetBase({32'd60, 32'd47}), .MaxOutstanding(4)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .csr_req_addr_i(req_addr), .csr_req_data_i(req_data), .csr_req_wen_i(req_wen),
    .csr_req_valid_i(req_valid), .csr_req_ready_o(req_ready),
    .csr_rsp_data_o(rsp_data), .csr_rsp_valid_o(rsp_valid), .csr_rsp_ready_i(rsp_ready),
    .acc_csr_req_addr_o(acc_addr), .acc_csr_req_data_o(acc_data), .acc_csr_req_wen_o(acc_wen),
    .acc_csr_req_valid_o(acc_valid), .acc_csr_req_ready_i(acc_req_ready),
    .acc_csr_rsp_data_i(acc_rsp_data), .acc_csr_rsp_valid_i(acc_rsp_valid),
    .acc_csr_rsp_ready_o(acc_rsp_ready), .busy_o(busy)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic wen, input logic [31:0] addr, input logic [31:0] data);
    req_valid = 1;
    req_wen = wen;
    req_addr = addr;
    req_data = data;
    #1;
  endtask
  task automatic idle();
    req_valid = 0;
    req_wen = 0;
    #1;
  endtask
  task automatic respond(input logic [2:0] v, input int t, input logic [31:0] d);
    acc_rsp_valid = v;
    acc_rsp_data = {3{32'hBAD0BAD0}};
    acc_rsp_data[t] = d;
    #1;
  endtask
  initial begin
    acc_rsp_data = '0;
    tick();
    tick();
    rst = 0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_acc_rsp_ready", acc_rsp_ready, 0);
    req(1, 10, 32'hD0);
    check("w10_valid", acc_valid, 3'b001);
    check("w10_addr", acc_addr[0], 10);
    check("w10_data", acc_data[0], 32'hD0);
    check("w10_wen", acc_wen[0], 1);
    check("w10_ready", req_ready, 1);
    tick();
    req(1, 50, 32'hD1);
    check("w50_valid", acc_valid, 3'b010);
    check("w50_addr", acc_addr[1], 3);
    tick();
    req(1, 70, 32'hD2);
    check("w70_valid", acc_valid, 3'b100);
    check("w70_addr", acc_addr[2], 10);
    tick();
    idle();
    check("w_busy", busy, 0);
    check("w_rsp_valid", rsp_valid, 0);
    // in-order return: target 0 answers first but must wait behind target 2
    req(0, 65, 0);
    check("r65_valid", acc_valid, 3'b100);
    check("r65_addr", acc_addr[2], 5);
    check("r65_wen", acc_wen[2], 0);
    tick();
    req(0, 5, 0);
    check("r5_valid", acc_valid, 3'b001);
    tick();
    idle();
    check("ord_busy", busy, 1);
    respond(3'b001, 0, 32'hAAAA);
    check("ord_held_valid", rsp_valid, 0);
    check("ord_held_ready", acc_rsp_ready, 3'b100);
    tick();
    respond(3'b101, 2, 32'h1234);
    acc_rsp_data[0] = 32'hAAAA;
    #1;
    check("ord_first_valid", rsp_valid, 1);
    check("ord_first_data", rsp_data, 32'h1234);
    check("ord_first_ready", acc_rsp_ready, 3'b100);
    tick();
    check("ord_second_data", rsp_data, 32'hAAAA);
    check("ord_second_ready", acc_rsp_ready, 3'b001);
    check("ord_second_busy", busy, 1);
    tick();
    respond(3'b000, 0, 0);
    check("ord_done_busy", busy, 0);
    // full: four reads to targets 0,1,2,0 with no responses
    req(0, 0, 0);
    check("full_r0_ready", req_ready, 1);
    tick();
    req(0, 50, 0);
    tick();
    req(0, 70, 0);
    tick();
    req(0, 1, 0);
    check("full_r3_ready", req_ready, 1);
    tick();
    req(0, 2, 0);
    check("full_r4_ready", req_ready, 0);
    check("full_r4_valid", acc_valid, 3'b000);
    req(1, 50, 32'hEE);
    check("full_w_ready", req_ready, 1);
    check("full_w_valid", acc_valid, 3'b010);
    tick();
    req(0, 2, 0);
    respond(3'b001, 0, 32'h11);
    check("full_pop_data", rsp_data, 32'h11);
    check("full_pop_nobypass", req_ready, 0);
    tick();
    respond(3'b000, 0, 0);
    check("full_after_pop_ready", req_ready, 1);
    tick();
    check("full_again_ready", req_ready, 0);
    idle();
    // queue now holds targets 1,2,0,0; drain two
    respond(3'b010, 1, 32'h21);
    check("drain1_data", rsp_data, 32'h21);
    tick();
    respond(3'b100, 2, 32'h22);
    check("drain2_data", rsp_data, 32'h22);
    tick();
    // simultaneous push and pop at count 2
    req(0, 50, 0);
    respond(3'b001, 0, 32'h31);
    check("pp_ready", req_ready, 1);
    check("pp_data", rsp_data, 32'h31);
    tick();
    idle();
    respond(3'b011, 0, 32'h32);
    acc_rsp_data[1] = 32'h41;
    #1;
    check("pp_order_data", rsp_data, 32'h32);
    check("pp_order_ready", acc_rsp_ready, 3'b001);
    tick();
    check("pp_last_data", rsp_data, 32'h41);
    check("pp_last_ready", acc_rsp_ready, 3'b010);
    tick();
    respond(3'b000, 0, 0);
    check("pp_busy", busy, 0);
    // wrap-around across both pointers
    for (int i = 0; i < 10; i++) begin
      int t;
      t = i % 2;
      req(0, t == 1 ? 47 + i : i, 0);
      check("wrap_req_valid", acc_valid, t == 1 ? 3'b010 : 3'b001);
      check("wrap_req_ready", req_ready, 1);
      tick();
      idle();
      respond(3'b011, t, 32'h100 + i);
      check("wrap_rsp_data", rsp_data, 32'h100 + i);
      tick();
      respond(3'b000, 0, 0);
    end
    check("wrap_busy", busy, 0);
    // reset with reads outstanding; a read presented during reset is dropped
    req(0, 0, 0);
    tick();
    req(0, 50, 0);
    tick();
    req(0, 70, 0);
    tick();
    check("rst_mid_busy", busy, 1);
    rst = 1;
    req(0, 5, 0);
    tick();
    rst = 0;
    idle();
    respond(3'b111, 0, 32'h55);
    check("rst_mid_busy_clr", busy, 0);
    check("rst_mid_rsp_valid", rsp_valid, 0);
    check("rst_mid_acc_ready", acc_rsp_ready, 3'b000);
    respond(3'b000, 0, 0);
    req(0, 70, 0);
    tick();
    idle();
    respond(3'b100, 2, 32'h77);
    check("post_rst_valid", rsp_valid, 1);
    check("post_rst_data", rsp_data, 32'h77);
    tick();
    respond(3'b000, 0, 0);
    check("post_rst_busy", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
